// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle HI/LO multiply/divide unit
//
// Purpose: iterative-latency mult/multu/div/divu with HI/LO result registers
//          and mthi/mtlo write port. Result is computed from operands latched
//          at launch and written to HI/LO on the last busy cycle.
// Ports:
//   clk    - clock, all state changes on rising edge
//   reset  - asynchronous active-high reset
//   start  - launch operation selected by op (ignored while busy)
//   op     - 00 mult, 01 multu, 10 div, 11 divu
//   a, b   - operands rs (multiplicand/dividend), rt (multiplier/divisor)
//   wr_hi  - mthi strobe (ignored while busy)
//   wr_lo  - mtlo strobe (ignored while busy)
//   wdata  - mthi/mtlo data
//   busy   - operation in progress
//   hi, lo - HI/LO registers
module muldiv_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MUL_N = MULT_CYCLES[3:0];
   localparam logic [3:0] DIV_N = DIV_CYCLES[3:0];

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        launch, done;
   logic [31:0] la, lb;
   logic [1:0]  lop;
   logic [63:0] prod;
   logic [31:0] res_hi, res_lo;

   // State, counter, latched operands, HI/LO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         la    <= 32'd0;
         lb    <= 32'd0;
         lop   <= 2'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (launch) begin
            la  <= a;
            lb  <= b;
            lop <= op;
         end
         if (done) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE) begin
            // A write coinciding with a launch lands now; the result overwrites it later.
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
      end
   end

   // Next state; the edge that takes cnt from 1 to 0 is the result edge,
   // so busy stays high for exactly the loaded count of cycles.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      launch  = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               launch  = 1'b1;
               state_n = op[1] ? DIV : MUL;
               cnt_n   = op[1] ? DIV_N : MUL_N;
            end
         end
         MUL, DIV: begin
            if (cnt <= 4'd1) begin
               done    = 1'b1;
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // Result datapath from latched operands only
   always_comb begin
      prod   = 64'd0;
      res_hi = 32'd0;
      res_lo = 32'd0;
      if (!lop[1]) begin
         if (lop[0])
            prod = {32'd0, la} * {32'd0, lb};
         else
            prod = $signed({{32{la[31]}}, la}) * $signed({{32{lb[31]}}, lb});
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end else if (lb == 32'd0) begin
         res_lo = 32'hFFFF_FFFF;
         res_hi = la;
      end else if (!lop[0] && la == 32'h8000_0000 && lb == 32'hFFFF_FFFF) begin
         // Signed overflow case: quotient wraps, remainder zero
         res_lo = 32'h8000_0000;
         res_hi = 32'd0;
      end else if (lop[0]) begin
         res_lo = la / lb;
         res_hi = la % lb;
      end else begin
         // Signed / and % truncate toward zero; remainder follows dividend sign
         res_lo = $signed(la) / $signed(lb);
         res_hi = $signed(la) % $signed(lb);
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic        busy;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Launch at a negedge, then count cycles with busy high (bounded)
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int n);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 10};
      vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      vecs[5] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 10};
      vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
      vecs[7] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
      vecs[8] = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 10};
      vecs[9] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset = 1'b0;

      // Table-driven operations
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
         check($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
         check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      end

      // mthi/mtlo while idle, both strobes together
      @(negedge clk);
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_1234;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b0;
      check("mthi_idle", hi, 32'h0000_1234);
      check("mtlo_idle", lo, 32'h0000_1234);

      // mtlo during busy ignored; result delivered afterwards
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'h0001_0000; b = 32'h0001_0000;
      @(negedge clk);
      start = 1'b0; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
      a = 32'd0; b = 32'd0;
      @(negedge clk);
      wr_lo = 1'b0;
      check("mtlo_busy_lo", lo, 32'h0000_1234);
      n = 0;
      while (busy && n < 40) begin n++; @(negedge clk); end
      check("mtlo_busy_res_hi", hi, 32'h0000_0001);
      check("mtlo_busy_res_lo", lo, 32'h0000_0000);

      // start while busy with new operands: ignored
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFE; b = 32'h0000_0003;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      @(negedge clk);
      n++;
      start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      n++;
      while (busy && n < 40) begin n++; @(negedge clk); end
      n--;
      check("relaunch_cycles", n, 5);
      check("relaunch_hi", hi, 32'hFFFF_FFFF);
      check("relaunch_lo", lo, 32'hFFFF_FFFA);
      check("relaunch_idle", {31'd0, busy}, 32'd0);

      // start together with mthi: write lands, result overwrites later
      start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
      wr_hi = 1'b1; wdata = 32'h0000_ABCD;
      @(negedge clk);
      start = 1'b0; wr_hi = 1'b0;
      check("start_wr_hi", hi, 32'h0000_ABCD);
      check("start_wr_busy", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 40) begin n++; @(negedge clk); end
      check("start_wr_res_hi", hi, 32'd0);
      check("start_wr_res_lo", lo, 32'd6);

      // reset mid-div aborts with no later write
      run_op_partial();
      #2 reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      check("abort_late_busy", {31'd0, busy}, 32'd0);
      check("abort_late_hi", hi, 32'd0);
      check("abort_late_lo", lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Launch div 7/2 and stop after four busy cycles
   task automatic run_op_partial();
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'd7; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_pre_busy", {31'd0, busy}, 32'd1);
   endtask

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu (legal 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  launch operation selected by op, sampled at rising edge.
REQ-006 SHALL have port op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port a  input  32  operand rs (multiplicand / dividend).
REQ-008 SHALL have port b  input  32  operand rt (multiplier / divisor).
REQ-009 SHALL have port wr_hi  input  1  mthi write strobe.
REQ-010 SHALL have port wr_lo  input  1  mtlo write strobe.
REQ-011 SHALL have port wdata  input  32  mthi/mtlo data.
REQ-012 SHALL have port busy  output  1  operation in progress; pipeline stalls mfhi/mflo/mult/div while high.
REQ-013 SHALL have port hi  output  32  HI register, registered output.
REQ-014 SHALL have port lo  output  32  LO register, registered output.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV plus 4-bit down-counter cnt.
REQ-016 SHALL, in IDLE with start=1 at an edge, latch a, b, op; enter MUL (op[1]=0) or DIV (op[1]=1); load cnt with MULT_CYCLES or DIV_CYCLES; busy=1 from that edge.
REQ-017 SHALL decrement cnt each edge in MUL/DIV; at the edge where cnt reaches 0, write HI/LO, return to IDLE, deassert busy — busy high exactly N cycles.
REQ-018 SHALL ignore start while busy=1 (no relaunch, no operand relatch).
REQ-019 SHALL compute mult as signed 32x32->64, multu unsigned; HI=product[63:32], LO=product[31:0].
REQ-020 SHALL compute div/divu: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-021 SHALL, on divisor 0 (div or divu), set LO=32'hFFFFFFFF, HI=latched a.
REQ-022 SHALL, on signed div of 32'h80000000 by 32'hFFFFFFFF, set LO=32'h80000000, HI=0.
REQ-023 SHALL compute results from latched operands only; a/b changes during busy have no effect.
REQ-024 SHALL, when busy=0, write wdata to HI on wr_hi and/or LO on wr_lo at the edge; both may assert together.
REQ-025 SHALL ignore wr_hi/wr_lo while busy=1.
REQ-026 SHALL, with start and wr_hi/wr_lo in same IDLE cycle, perform the write at that edge and launch the operation; result later overwrites HI/LO.
REQ-027 SHALL keep hi/lo stable except at write or result edges.
REQ-028 SHALL hold FSM in IDLE and ignore op when start=0.

Reset
REQ-029 SHALL, on reset=1, asynchronously force state IDLE, cnt=0, busy=0, hi=0, lo=0, latched operands 0.
REQ-030 SHALL abort any in-progress operation on reset with no HI/LO update; first edge after release behaves as IDLE.

Verification
REQ-031 SHALL test mult a=32'hFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-032 SHALL test multu a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 after 5 busy cycles.
REQ-033 SHALL test div a=-7 (32'hFFFFFFF9), b=2 -> busy 10 cycles, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; divu a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-034 SHALL test mthi 32'h1234 while idle -> hi=32'h1234 next edge; mtlo during busy -> lo unchanged until result.
REQ-035 SHALL test start pulse while busy (new operands) -> ignored, original result delivered, busy length unchanged.
REQ-036 SHALL test reset asserted mid-div (cycle 4) -> busy, hi, lo =0 immediately, no later result write.
